lcd_bus_responder: RTL and testbench
====================================

Name: lcd_bus_responder

Overview:
- Synthesizable responder for the HD44780-style 8-bit LCD bus (RS, RW, E, DB) driven by the display control unit.
- Decodes writes into a 2x16 character buffer plus control flags, and answers busy-flag and data reads.
- Used as an on-chip display shadow and as the bus model in display-path benches.
- Samples the asynchronous bus signals on clock50MHz.

Parameters:
- BUSY_CYCLES, 2000, busy duration for ordinary commands and data writes (40 us at 50 MHz).
- CLEAR_CYCLES, 82000, busy duration for clear display and return home (1.64 ms).

Ports:
- clock50MHz  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- RS  input  1  register select: 0 = command/status, 1 = data
- RW  input  1  0 = write, 1 = read
- E  input  1  enable strobe
- DB_in  input  8  bus data from the controller
- DB_out  output  8  bus data returned on reads
- DB_oe  output  1  DB_out drive enable
- busy  output  1  internal busy flag
- addr_counter  output  7  DDRAM address counter (AC)
- display_on  output  1  D bit
- cursor_on  output  1  C bit
- blink_on  output  1  B bit
- peek_idx  input  5  character buffer index {line, column}
- peek_char  output  8  buffer contents at peek_idx (combinational)
- overrun  output  1  sticky flag: access attempted while busy

Behaviour:
- Reset (reset=0, asynchronous):
  - all 32 buffer bytes = 0x20; AC = 0x00; I/D = 1.
  - display_on, cursor_on, blink_on = 0.
  - busy = 0 and busy counter = 0.
  - DB_out = 0x00; DB_oe = 0; overrun = 0.
- Reset mid-operation aborts busy immediately. Reset has priority over any E edge.
- Input sync: RS, RW, E and DB_in each pass through 2 flops. Edges are detected on the synchronized E. The strobe edge is seen 3 cycles after the pin edge.
- Write (RW=0): RS and DB are captured on the synchronized E falling edge. Commit occurs on the next cycle, and busy rises in that same cycle.
- Command decode, highest set bit wins:
  - 1xxxxxxx: AC = {DB[6],2'b00,DB[3:0]}; bits 5:4 ignored; busy BUSY_CYCLES.
  - 001xxxxx: function set, stored only; busy BUSY_CYCLES.
  - 00001DCB: update display_on, cursor_on, blink_on; busy BUSY_CYCLES.
  - 000001IS: I/D = I; S ignored; busy BUSY_CYCLES.
  - 0000001x: AC = 0; busy CLEAR_CYCLES.
  - 00000001: all buffer bytes = 0x20, AC = 0, I/D = 1; busy CLEAR_CYCLES.
  - 0x00: no-op; no busy.
- Data write (RS=1): buffer[{AC[6],AC[3:0]}] = DB, then AC steps. Busy for BUSY_CYCLES.
- AC step:
  - I/D=1: 0x0F -> 0x40; 0x4F -> 0x00; otherwise +1.
  - I/D=0: 0x00 -> 0x4F; 0x40 -> 0x0F; otherwise -1.
- Busy counter:
  - Loads N-1 at commit and busy = 1.
  - busy stays 1 while the counter > 0 and drops on the cycle after the counter reaches 0.
  - Exactly N busy cycles.
- Any write, or data read, whose falling edge is detected while busy=1:
  - The access is ignored; no state change and no AC step.
  - overrun is set and stays set until reset.
- Status read (RW=1, RS=0): while synchronized E=1, DB_oe = 1 and DB_out = {busy, AC}.
  - DB_out updates every cycle, so busy can be observed falling mid-strobe.
  - Status reads never set overrun.
- Data read (RW=1, RS=1): while synchronized E=1, DB_oe = 1 and DB_out = buffer[AC].
  - On the falling edge, AC steps per I/D.
  - No busy period follows a data read.
- DB_oe drops on the cycle after synchronized E falls. DB_out holds its last value.
- RW or RS changes while E is high: the values captured at the falling edge decide the access type.

Decomposition:
- Package lcd_pkg:
  - opcode masks and opcode values
  - LINE0_BASE=0x00, LINE1_BASE=0x40, SPACE=0x20
  - BUSY/CLEAR default constants
  - AC step function
- Sub-module lcd_bus_sync: 2-flop synchronizers for RS, RW, E and DB_in, plus rise/fall pulses of E.

Test Plan:
- Reset, then issue 0x38, 0x0C, 0x06, each spaced > BUSY_CYCLES -> display_on=1, cursor_on=0, blink_on=0, I/D=1, overrun=0.
- Write 0x80, then data 0x48 and 0x49 -> peek_char[0]=0x48, peek_char[1]=0x49, addr_counter=0x02.
- Write 0x8F, then data 0x41 -> peek_char[15]=0x41, addr_counter=0x40. Repeat at 0xCF -> addr_counter wraps to 0x00.
- Write 0x01, then status-poll -> DB_out[7]=1 for exactly 82000 cycles, all 32 bytes = 0x20, AC=0.
- Write data 0x55 one cycle after a command commit -> byte unchanged, AC unchanged, overrun=1 and stays set.
- Set AC=0x45 and write 0x04, then data-read twice -> DB_out = buffer[0x45], then buffer[0x44]. Assert reset mid-CLEAR -> busy=0 immediately and the buffer is all 0x20.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// lcd_pkg: opcode encodings, address constants and AC stepping for the
//          HD44780-style bus responder.                     Rev 1.0
// ============================================================================
package lcd_pkg;

  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [7:0] SPACE      = 8'h20;

  localparam int BUSY_CYCLES_DEFAULT  = 2000;
  localparam int CLEAR_CYCLES_DEFAULT = 82000;

  localparam logic [7:0] OP_SET_DDRAM_MASK = 8'h80;
  localparam logic [7:0] OP_SET_DDRAM      = 8'h80;
  localparam logic [7:0] OP_FUNC_MASK      = 8'hE0;
  localparam logic [7:0] OP_FUNC           = 8'h20;
  localparam logic [7:0] OP_SHIFT_MASK     = 8'hF0;
  localparam logic [7:0] OP_SHIFT          = 8'h10;
  localparam logic [7:0] OP_DISPLAY_MASK   = 8'hF8;
  localparam logic [7:0] OP_DISPLAY        = 8'h08;
  localparam logic [7:0] OP_ENTRY_MASK     = 8'hFC;
  localparam logic [7:0] OP_ENTRY          = 8'h04;
  localparam logic [7:0] OP_HOME_MASK      = 8'hFE;
  localparam logic [7:0] OP_HOME           = 8'h02;
  localparam logic [7:0] OP_CLEAR_MASK     = 8'hFF;
  localparam logic [7:0] OP_CLEAR          = 8'h01;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_CLEAR,
    CMD_HOME,
    CMD_ENTRY,
    CMD_DISPLAY,
    CMD_SHIFT,
    CMD_FUNC,
    CMD_SET_DDRAM
  } cmd_e;

  // Highest set bit selects the instruction.
  function automatic cmd_e cmd_decode(input logic [7:0] db);
    if ((db & OP_SET_DDRAM_MASK) == OP_SET_DDRAM) return CMD_SET_DDRAM;
    if ((db & OP_FUNC_MASK)      == OP_FUNC)      return CMD_FUNC;
    if ((db & OP_SHIFT_MASK)     == OP_SHIFT)     return CMD_SHIFT;
    if ((db & OP_DISPLAY_MASK)   == OP_DISPLAY)   return CMD_DISPLAY;
    if ((db & OP_ENTRY_MASK)     == OP_ENTRY)     return CMD_ENTRY;
    if ((db & OP_HOME_MASK)      == OP_HOME)      return CMD_HOME;
    if ((db & OP_CLEAR_MASK)     == OP_CLEAR)     return CMD_CLEAR;
    return CMD_NOP;
  endfunction

  // AC walks line 0 then line 1 as one 32-character ring.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic id);
    logic [6:0] nxt;
    if (id) begin
      if (ac == LINE0_BASE + 7'h0F)      nxt = LINE1_BASE;
      else if (ac == LINE1_BASE + 7'h0F) nxt = LINE0_BASE;
      else                               nxt = ac + 7'd1;
    end else begin
      if (ac == LINE0_BASE)              nxt = LINE1_BASE + 7'h0F;
      else if (ac == LINE1_BASE)         nxt = LINE0_BASE + 7'h0F;
      else                               nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_sync.sv
`default_nettype none
// ============================================================================
// lcd_bus_sync: 2-flop synchronizers for RS, RW, E, DB and E falling-edge
//               detection.                                  Rev 1.0
// ============================================================================
module lcd_bus_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rs,
  input  logic       i_rw,
  input  logic       i_e,
  input  logic [7:0] i_db,
  output logic       o_rs,
  output logic       o_rw,
  output logic       o_e,
  output logic [7:0] o_db,
  output logic       o_e_fall
);

  logic [10:0] r_meta;
  logic [10:0] r_sync;
  logic        r_e_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
      r_e_d  <= 1'b0;
    end else begin
      r_meta <= {i_rs, i_rw, i_e, i_db};
      r_sync <= r_meta;
      r_e_d  <= r_sync[8];
    end
  end

  assign {o_rs, o_rw, o_e, o_db} = r_sync;
  assign o_e_fall = r_e_d & ~r_sync[8];

endmodule
`default_nettype wire

// File: rtl/lcd_bus_responder.sv
`default_nettype none
// ============================================================================
// lcd_bus_responder: HD44780-style bus slave keeping a 2x16 character shadow,
//                    display flags, busy timing and read-back.  Rev 1.0
// ============================================================================
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES  = BUSY_CYCLES_DEFAULT,
  parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEFAULT
) (
  input  logic       clock50MHz,
  input  logic       reset,
  input  logic       RS,
  input  logic       RW,
  input  logic       E,
  input  logic [7:0] DB_in,
  output logic [7:0] DB_out,
  output logic       DB_oe,
  output logic       busy,
  output logic [6:0] addr_counter,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  input  logic [4:0] peek_idx,
  output logic [7:0] peek_char,
  output logic       overrun
);

  localparam int c_max_cycles = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int c_cnt_w      = (c_max_cycles > 2) ? $clog2(c_max_cycles) : 1;
  localparam logic [c_cnt_w-1:0] c_busy_load  = c_cnt_w'(BUSY_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_clear_load = c_cnt_w'(CLEAR_CYCLES - 1);

  logic       w_rs, w_rw, w_e, w_e_fall;
  logic [7:0] w_db;
  logic [4:0] w_ac_idx;

  logic [7:0]         r_buf [32];
  logic [6:0]         r_ac;
  logic               r_id;
  logic               r_disp, r_cur, r_blink;
  logic               r_busy;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_pend;
  logic               r_cap_rs, r_cap_rw;
  logic [7:0]         r_cap_db;
  logic [7:0]         r_db_out;
  logic               r_db_oe;
  logic               r_overrun;

  lcd_bus_sync u_sync (
    .clk      (clock50MHz),
    .rst_n    (reset),
    .i_rs     (RS),
    .i_rw     (RW),
    .i_e      (E),
    .i_db     (DB_in),
    .o_rs     (w_rs),
    .o_rw     (w_rw),
    .o_e      (w_e),
    .o_db     (w_db),
    .o_e_fall (w_e_fall)
  );

  // Buffer index is {line, column}; AC bits 5:4 never address storage.
  assign w_ac_idx = {r_ac[6], r_ac[3:0]};

  always_ff @(posedge clock50MHz or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_buf[i] <= SPACE;
      r_ac      <= LINE0_BASE;
      r_id      <= 1'b1;
      r_disp    <= 1'b0;
      r_cur     <= 1'b0;
      r_blink   <= 1'b0;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_pend    <= 1'b0;
      r_cap_rs  <= 1'b0;
      r_cap_rw  <= 1'b0;
      r_cap_db  <= 8'h00;
      r_db_out  <= 8'h00;
      r_db_oe   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // Strobe end: status reads carry no side effect, everything else is
      // either queued for commit or rejected as an overrun.
      r_pend <= 1'b0;
      if (w_e_fall && !(w_rw && !w_rs)) begin
        if (r_busy) begin
          r_overrun <= 1'b1;
        end else begin
          r_pend   <= 1'b1;
          r_cap_rs <= w_rs;
          r_cap_rw <= w_rw;
          r_cap_db <= w_db;
        end
      end

      if (r_busy) begin
        if (r_cnt != '0) r_cnt  <= r_cnt - c_cnt_w'(1);
        else             r_busy <= 1'b0;
      end

      // Commit; a busy load here overrides the countdown above.
      if (r_pend) begin
        if (r_cap_rw) begin
          r_ac <= ac_step(r_ac, r_id);
        end else if (r_cap_rs) begin
          r_buf[w_ac_idx] <= r_cap_db;
          r_ac   <= ac_step(r_ac, r_id);
          r_busy <= 1'b1;
          r_cnt  <= c_busy_load;
        end else begin
          case (cmd_decode(r_cap_db))
            CMD_SET_DDRAM: begin
              r_ac   <= {r_cap_db[6], 2'b00, r_cap_db[3:0]};
              r_busy <= 1'b1;
              r_cnt  <= c_busy_load;
            end
            CMD_FUNC, CMD_SHIFT: begin
              r_busy <= 1'b1;
              r_cnt  <= c_busy_load;
            end
            CMD_DISPLAY: begin
              r_disp  <= r_cap_db[2];
              r_cur   <= r_cap_db[1];
              r_blink <= r_cap_db[0];
              r_busy  <= 1'b1;
              r_cnt   <= c_busy_load;
            end
            CMD_ENTRY: begin
              r_id   <= r_cap_db[1];
              r_busy <= 1'b1;
              r_cnt  <= c_busy_load;
            end
            CMD_HOME: begin
              r_ac   <= LINE0_BASE;
              r_busy <= 1'b1;
              r_cnt  <= c_clear_load;
            end
            CMD_CLEAR: begin
              for (int i = 0; i < 32; i++) r_buf[i] <= SPACE;
              r_ac   <= LINE0_BASE;
              r_id   <= 1'b1;
              r_busy <= 1'b1;
              r_cnt  <= c_clear_load;
            end
            default: ;
          endcase
        end
      end

      // Read drive follows the synchronized strobe level every cycle.
      if (w_e && w_rw) begin
        r_db_oe  <= 1'b1;
        r_db_out <= w_rs ? r_buf[w_ac_idx] : {r_busy, r_ac};
      end else begin
        r_db_oe  <= 1'b0;
      end
    end
  end

  assign DB_out       = r_db_out;
  assign DB_oe        = r_db_oe;
  assign busy         = r_busy;
  assign addr_counter = r_ac;
  assign display_on   = r_disp;
  assign cursor_on    = r_cur;
  assign blink_on     = r_blink;
  assign overrun      = r_overrun;
  assign peek_char    = r_buf[peek_idx];

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_responder.sv
`default_nettype none
// ============================================================================
// tb_lcd_bus_responder: directed table, corner sequences and randomized
//                       accesses checked against a behavioural model. Rev 1.0
// ============================================================================
module tb_lcd_bus_responder;

  localparam int BUSY_N  = 24;
  localparam int CLEAR_N = 60;
  localparam int GAP     = 70;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rs = 1'b0, rw = 1'b0, e = 1'b0;
  logic [7:0] db = 8'h00;
  logic [4:0] peek_idx = 5'd0;
  logic [7:0] db_out, peek_char;
  logic       db_oe, busy, display_on, cursor_on, blink_on, overrun;
  logic [6:0] addr_counter;

  always #5 clk = ~clk;

  lcd_bus_responder #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
    .clock50MHz   (clk),
    .reset        (rst_n),
    .RS           (rs),
    .RW           (rw),
    .E            (e),
    .DB_in        (db),
    .DB_out       (db_out),
    .DB_oe        (db_oe),
    .busy         (busy),
    .addr_counter (addr_counter),
    .display_on   (display_on),
    .cursor_on    (cursor_on),
    .blink_on     (blink_on),
    .peek_idx     (peek_idx),
    .peek_char    (peek_char),
    .overrun      (overrun)
  );

  int vectors = 0;
  int miscompares = 0;
  int bcnt = 0;

  always @(negedge clk) if (busy) bcnt <= bcnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full bus cycle: strobe high 5 clocks, sample read data, then hold
  // RS/RW/DB long enough for the synchronized falling edge to commit.
  task automatic access(input logic s, input logic w, input logic [7:0] d,
                        output logic [7:0] rd, output logic oe);
    @(negedge clk);
    rs = s; rw = w; db = d; e = 1'b1;
    repeat (5) @(negedge clk);
    rd = db_out; oe = db_oe;
    e = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic chk_peek(input string nm, input logic [4:0] idx, input logic [7:0] exp);
    peek_idx = idx;
    #1;
    chk(nm, {24'h0, peek_char}, {24'h0, exp});
  endtask

  task automatic chk_all_space(input string nm);
    for (int i = 0; i < 32; i++) chk_peek(nm, 5'(i), 8'h20);
  endtask

  task automatic chk_reset_state();
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ac", {25'h0, addr_counter}, 32'h0);
    chk("rst_oe", {31'h0, db_oe}, 32'h0);
    chk("rst_dbout", {24'h0, db_out}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
    chk("rst_dcb", {29'h0, display_on, cursor_on, blink_on}, 32'h0);
    chk_all_space("rst_buf");
  endtask

  // ---------------- behavioural model: AC as a position on a 32-char ring
  logic [7:0] mbuf [32];
  int  mpos;
  bit  mid, md, mc, mb, movr, mbusy;

  function automatic logic [6:0] mac(input int pos);
    return 7'((pos / 16) * 64 + (pos % 16));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    mpos = 0; mid = 1; md = 0; mc = 0; mb = 0; movr = 0; mbusy = 0;
  endtask

  task automatic model_step();
    mpos = mid ? (mpos + 1) % 32 : (mpos + 31) % 32;
  endtask

  task automatic model_cmd(input logic [7:0] d);
    if (d[7])      mpos = (d[6] ? 16 : 0) + int'(d[3:0]);
    else if (d[5]) ;
    else if (d[3]) {md, mc, mb} = d[2:0];
    else if (d[2]) mid = d[1];
    else if (d[1]) mpos = 0;
    else if (d[0]) begin
      for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
      mpos = 0; mid = 1;
    end
  endtask

  function automatic logic [7:0] rand_cmd();
    case ($urandom_range(0, 6))
      0:       return 8'h80 | 8'($urandom_range(0, 127));
      1:       return 8'h20 | 8'($urandom_range(0, 31));
      2:       return 8'h08 | 8'($urandom_range(0, 7));
      3:       return 8'h04 | 8'($urandom_range(0, 3));
      4:       return 8'h02 | 8'($urandom_range(0, 1));
      5:       return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  typedef struct {
    logic       rs;
    logic [7:0] db;
    logic [6:0] ac;
    logic [2:0] dcb;
    logic       pk;
    logic [4:0] pidx;
    logic [7:0] pch;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic       oe;
    int         b0;

    tbl[0]  = '{1'b0, 8'h38, 7'h00, 3'b000, 1'b0, 5'd0,  8'h00};
    tbl[1]  = '{1'b0, 8'h0C, 7'h00, 3'b100, 1'b0, 5'd0,  8'h00};
    tbl[2]  = '{1'b0, 8'h06, 7'h00, 3'b100, 1'b0, 5'd0,  8'h00};
    tbl[3]  = '{1'b0, 8'h80, 7'h00, 3'b100, 1'b0, 5'd0,  8'h00};
    tbl[4]  = '{1'b1, 8'h48, 7'h01, 3'b100, 1'b1, 5'd0,  8'h48};
    tbl[5]  = '{1'b1, 8'h49, 7'h02, 3'b100, 1'b1, 5'd1,  8'h49};
    tbl[6]  = '{1'b0, 8'h8F, 7'h0F, 3'b100, 1'b0, 5'd0,  8'h00};
    tbl[7]  = '{1'b1, 8'h41, 7'h40, 3'b100, 1'b1, 5'd15, 8'h41};
    tbl[8]  = '{1'b0, 8'hCF, 7'h4F, 3'b100, 1'b0, 5'd0,  8'h00};
    tbl[9]  = '{1'b1, 8'h5A, 7'h00, 3'b100, 1'b1, 5'd31, 8'h5A};
    tbl[10] = '{1'b0, 8'h0F, 7'h00, 3'b111, 1'b0, 5'd0,  8'h00};
    tbl[11] = '{1'b0, 8'hB3, 7'h03, 3'b111, 1'b0, 5'd0,  8'h00};
    tbl[12] = '{1'b0, 8'h0D, 7'h03, 3'b101, 1'b1, 5'd0,  8'h48};

    wait_cycles(3);
    chk_reset_state();
    rst_n = 1'b1;
    wait_cycles(3);

    for (int i = 0; i < 13; i++) begin
      access(tbl[i].rs, 1'b0, tbl[i].db, rd, oe);
      wait_cycles(GAP);
      chk("tbl_ac", {25'h0, addr_counter}, {25'h0, tbl[i].ac});
      chk("tbl_dcb", {29'h0, display_on, cursor_on, blink_on}, {29'h0, tbl[i].dcb});
      chk("tbl_overrun", {31'h0, overrun}, 32'h0);
      if (tbl[i].pk) chk_peek("tbl_peek", tbl[i].pidx, tbl[i].pch);
    end

    // Clear display: busy length, status poll mid-clear, buffer wiped.
    b0 = bcnt;
    access(1'b0, 1'b0, 8'h01, rd, oe);
    access(1'b0, 1'b1, 8'h00, rd, oe);
    chk("clr_status_oe", {31'h0, oe}, 32'h1);
    chk("clr_status", {24'h0, rd}, 32'h80);
    wait_cycles(GAP);
    chk("clr_busy_len", bcnt - b0, CLEAR_N);
    chk("clr_busy_end", {31'h0, busy}, 32'h0);
    chk("clr_ac", {25'h0, addr_counter}, 32'h0);
    chk_all_space("clr_buf");
    access(1'b0, 1'b1, 8'h00, rd, oe);
    chk("idle_status", {24'h0, rd}, 32'h00);

    // Data write landing inside a command's busy window.
    access(1'b0, 1'b0, 8'h80, rd, oe);
    access(1'b1, 1'b0, 8'h55, rd, oe);
    chk_peek("ovr_byte", 5'd0, 8'h20);
    chk("ovr_ac", {25'h0, addr_counter}, 32'h0);
    chk("ovr_flag", {31'h0, overrun}, 32'h1);
    wait_cycles(GAP);
    access(1'b1, 1'b0, 8'h33, rd, oe);
    wait_cycles(GAP);
    chk_peek("ovr_after_byte", 5'd0, 8'h33);
    chk("ovr_after_ac", {25'h0, addr_counter}, 32'h01);
    chk("ovr_sticky", {31'h0, overrun}, 32'h1);

    // Decrementing data reads, including the 0x00 -> 0x4F wrap.
    access(1'b0, 1'b0, 8'hC4, rd, oe); wait_cycles(GAP);
    access(1'b1, 1'b0, 8'h61, rd, oe); wait_cycles(GAP);
    access(1'b1, 1'b0, 8'h62, rd, oe); wait_cycles(GAP);
    access(1'b0, 1'b0, 8'hC5, rd, oe); wait_cycles(GAP);
    access(1'b0, 1'b0, 8'h04, rd, oe); wait_cycles(GAP);
    access(1'b1, 1'b1, 8'h00, rd, oe);
    chk("rd1_data", {24'h0, rd}, 32'h62);
    chk("rd1_oe", {31'h0, oe}, 32'h1);
    chk("rd1_oe_drop", {31'h0, db_oe}, 32'h0);
    chk("rd1_ac", {25'h0, addr_counter}, 32'h44);
    chk("rd1_no_busy", {31'h0, busy}, 32'h0);
    access(1'b1, 1'b1, 8'h00, rd, oe);
    chk("rd2_data", {24'h0, rd}, 32'h61);
    chk("rd2_ac", {25'h0, addr_counter}, 32'h43);
    chk("rd2_hold", {24'h0, db_out}, 32'h61);
    access(1'b0, 1'b0, 8'h80, rd, oe); wait_cycles(GAP);
    access(1'b1, 1'b1, 8'h00, rd, oe);
    chk("rd3_data", {24'h0, rd}, 32'h33);
    chk("rd3_wrap_ac", {25'h0, addr_counter}, 32'h4F);

    // Reset while a clear is still busy.
    wait_cycles(GAP);
    access(1'b0, 1'b0, 8'h01, rd, oe);
    wait_cycles(10);
    chk("midclr_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_state();
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(3);

    // Randomized accesses, occasionally packed into the previous busy window.
    model_reset();
    begin
      bit prev_short = 0;
      for (int it = 0; it < 150; it++) begin
        bit         sh, busy_now;
        logic [7:0] d, exp_rd;
        logic [4:0] pidx;
        sh = !prev_short && ($urandom_range(0, 3) == 0);
        if (sh) wait_cycles($urandom_range(0, 2));
        else    wait_cycles(GAP);
        busy_now = sh && mbusy;
        case ($urandom_range(0, 3))
          0: begin
            d = rand_cmd();
            access(1'b0, 1'b0, d, rd, oe);
            if (busy_now) movr = 1; else model_cmd(d);
            mbusy = !busy_now && (d != 8'h00);
          end
          1: begin
            d = 8'($urandom);
            access(1'b1, 1'b0, d, rd, oe);
            if (busy_now) movr = 1;
            else begin mbuf[mpos] = d; model_step(); end
            mbusy = !busy_now;
          end
          2: begin
            exp_rd = mbuf[mpos];
            access(1'b1, 1'b1, 8'h00, rd, oe);
            chk("rnd_rd_data", {24'h0, rd}, {24'h0, exp_rd});
            chk("rnd_rd_oe", {31'h0, oe}, 32'h1);
            if (busy_now) movr = 1; else model_step();
            mbusy = 0;
          end
          default: begin
            access(1'b0, 1'b1, 8'h00, rd, oe);
            chk("rnd_status", {24'h0, rd}, {24'h0, busy_now, mac(mpos)});
            mbusy = 0;
          end
        endcase
        chk("rnd_ac", {25'h0, addr_counter}, {25'h0, mac(mpos)});
        chk("rnd_dcb", {29'h0, display_on, cursor_on, blink_on}, {29'h0, md, mc, mb});
        chk("rnd_overrun", {31'h0, overrun}, {31'h0, movr});
        pidx = 5'($urandom_range(0, 31));
        chk_peek("rnd_peek", pidx, mbuf[pidx]);
        prev_short = sh;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
